re_name_commit: RTL and testbench

RE_NAME_COMMIT -- requirements
Module: re_name_commit

---
 rtl/ariane_pkg.sv | 38 +++
 rtl/re_name_commit_if.sv | 23 ++
 rtl/re_name_check.sv | 35 +++
 rtl/re_name_commit.sv | 105 ++++++++++
 tb/tb_re_name_commit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - scoreboard entry type, rename switch and FP operand helpers
// Shared by re_name_commit and its checker.
package ariane_pkg;

  localparam bit ENABLE_RENAME = 1'b1;

  typedef enum logic [3:0] {
    ADD, SUB, LD, SD, FLD, FSD, FADD, FMUL, FMADD, FMV_X2F, FMV_F2X
  } fu_op;

  typedef struct packed {
    logic [31:0] pc;
    fu_op        op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [63:0] result;
    logic        valid;
  } scoreboard_entry_t;

  typedef enum logic {RUN = 1'b0, RESTORE = 1'b1} commit_state_t;

  function automatic logic is_rd_fpr(input fu_op op);
    case (op)
      FLD, FADD, FMUL, FMADD, FMV_X2F: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Fused ops carry their third FP source register in the result field
  function automatic logic is_imm_fpr(input fu_op op);
    case (op)
      FMADD:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/re_name_commit_if.sv
// rtl/re_name_commit_if.sv - commit and writeback handshake bundle
// master drives commits and accepts writebacks; slave is the commit stage.
interface re_name_commit_if;
  import ariane_pkg::*;

  scoreboard_entry_t commit_instr;
  logic              commit_valid;
  logic              commit_ack;
  scoreboard_entry_t wb_instr;
  logic              wb_valid;
  logic              wb_ready;

  modport master (
    output commit_instr, commit_valid, wb_ready,
    input  commit_ack, wb_instr, wb_valid
  );

  modport slave (
    input  commit_instr, commit_valid, wb_ready,
    output commit_ack, wb_instr, wb_valid
  );

endinterface

// File: rtl/re_name_check.sv
// rtl/re_name_check.sv - name-bit sequence checker with sticky error and saturating count
// The table bit is the committed name before this commit's toggle.
module re_name_check
  import ariane_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 accept,
  input  logic [5:0]           rd,
  input  logic                 is_fpr,
  input  logic                 table_bit,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] count
);

  logic expected;
  logic mismatch;

  // GPR x0 is never renamed, so its name bit must always be zero
  assign expected = (!is_fpr && rd[4:0] == 5'd0) ? 1'b0 : (ENABLE_RENAME & ~table_bit);
  assign mismatch = accept && (rd[5] != expected);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      error <= 1'b0;
      count <= '0;
    end else if (mismatch) begin
      error <= 1'b1;
      if (count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/re_name_commit.sv
// rtl/re_name_commit.sv - commit-side de-rename with committed name tables and restore
// Optional name checker enabled by RE_NAME_CHECK_EN.
module re_name_commit
  import ariane_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  scoreboard_entry_t    commit_instr_i,
  input  logic                 commit_valid_i,
  output logic                 commit_ack_o,
  output scoreboard_entry_t    wb_instr_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [31:0]          restore_gpr_o,
  output logic [31:0]          restore_fpr_o,
  output logic                 restore_valid_o,
  output logic                 error_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  commit_state_t     state_q;
  logic [31:0]       cgpr_q;
  logic [31:0]       cfpr_q;
  scoreboard_entry_t wb_q;
  scoreboard_entry_t wb_d;
  logic              wb_valid_q;
  logic              accept;
  logic              rd_fpr;
  logic [4:0]        rd_idx;

  assign rd_idx = commit_instr_i.rd[4:0];
  assign rd_fpr = is_rd_fpr(commit_instr_i.op);

  assign commit_ack_o = !rst_i && (state_q == RUN) && (!wb_valid_q || wb_ready_i);
  assign accept       = commit_valid_i && commit_ack_o;

  always_comb begin
    wb_d        = commit_instr_i;
    wb_d.rd[5]  = 1'b0;
    wb_d.rs1[5] = 1'b0;
    wb_d.rs2[5] = 1'b0;
    if (is_imm_fpr(commit_instr_i.op)) wb_d.result[5] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      cgpr_q     <= '0;
      cfpr_q     <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      case (state_q)
        RUN:     state_q <= flush_i ? RESTORE : RUN;
        RESTORE: state_q <= flush_i ? RESTORE : RUN;
        default: state_q <= RUN;
      endcase

      if (accept) begin
        if (rd_fpr)               cfpr_q[rd_idx] <= ~cfpr_q[rd_idx];
        else if (rd_idx != 5'd0)  cgpr_q[rd_idx] <= ~cgpr_q[rd_idx];
      end

      // Flush never discards the output register: committed work must retire
      if (accept) begin
        wb_q       <= wb_d;
        wb_valid_q <= 1'b1;
      end else if (wb_ready_i) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign wb_instr_o      = wb_q;
  assign wb_valid_o      = wb_valid_q;
  assign restore_gpr_o   = cgpr_q;
  assign restore_fpr_o   = cfpr_q;
  assign restore_valid_o = (state_q == RESTORE);

`ifdef RE_NAME_CHECK_EN
  logic table_bit;

  assign table_bit = rd_fpr ? cfpr_q[rd_idx] : cgpr_q[rd_idx];

  re_name_check #(
    .ERR_CNT_W(ERR_CNT_W)
  ) u_check (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .accept    (accept),
    .rd        (commit_instr_i.rd),
    .is_fpr    (rd_fpr),
    .table_bit (table_bit),
    .error     (error_o),
    .count     (err_cnt_o)
  );
`else
  assign error_o   = 1'b0;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_re_name_commit.sv
// tb/tb_re_name_commit.sv - directed bench for re_name_commit
// Expectations for error_o/err_cnt_o follow RE_NAME_CHECK_EN.
module tb_re_name_commit;
  import ariane_pkg::*;

`ifdef RE_NAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] restore_gpr;
  logic [31:0] restore_fpr;
  logic        restore_valid;
  logic        error;
  logic [7:0]  err_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  re_name_commit_if bus ();

  re_name_commit #(.ERR_CNT_W(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .commit_instr_i  (bus.commit_instr),
    .commit_valid_i  (bus.commit_valid),
    .commit_ack_o    (bus.commit_ack),
    .wb_instr_o      (bus.wb_instr),
    .wb_valid_o      (bus.wb_valid),
    .wb_ready_i      (bus.wb_ready),
    .restore_gpr_o   (restore_gpr),
    .restore_fpr_o   (restore_fpr),
    .restore_valid_o (restore_valid),
    .error_o         (error),
    .err_cnt_o       (err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic scoreboard_entry_t mk(input fu_op op, input logic [5:0] rd,
                                           input logic [5:0] rs1, input logic [5:0] rs2,
                                           input logic [63:0] res);
    scoreboard_entry_t e;
    e        = '0;
    e.pc     = 32'h8000_0000;
    e.op     = op;
    e.rd     = rd;
    e.rs1    = rs1;
    e.rs2    = rs2;
    e.result = res;
    e.valid  = 1'b1;
    return e;
  endfunction

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    bus.wb_ready     = 1'b1;
    bus.commit_valid = 1'b1;
    bus.commit_instr = mk(ADD, 6'h25, 6'h21, 6'h22, 64'h25);
    #2;
    chk("ack_in_reset", bus.commit_ack, 0);
    tick();
    tick();
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_restore_valid", restore_valid, 0);
    chk("rst_gpr", restore_gpr, 0);
    chk("rst_fpr", restore_fpr, 0);
    chk("rst_error", error, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // first GPR commit of x5 with name bit 1
    rst = 1'b0;
    #1;
    chk("ack_x5", bus.commit_ack, 1);
    tick();
    chk("wb_valid_x5", bus.wb_valid, 1);
    chk("wb_rd_x5", bus.wb_instr.rd, 6'h05);
    chk("wb_rs1_x5", bus.wb_instr.rs1, 6'h01);
    chk("wb_rs2_x5", bus.wb_instr.rs2, 6'h02);
    chk("wb_res_x5", bus.wb_instr.result, 64'h25);
    chk("gpr_x5", restore_gpr, 32'h20);
    chk("err_x5", error, 0);

    // x0 never toggles
    for (int i = 0; i < 3; i++) begin
      bus.commit_instr = mk(ADD, 6'h00, 6'h00, 6'h00, 64'h0);
      #1;
      chk("ack_x0", bus.commit_ack, 1);
      tick();
      chk("wb_rd_x0", bus.wb_instr.rd, 6'h00);
      chk("gpr_x0", restore_gpr, 32'h20);
    end
    chk("err_x0", error, 0);
    chk("cnt_x0", err_cnt, 0);

    // writeback backpressure
    bus.commit_instr = mk(ADD, 6'h26, 6'h01, 6'h02, 64'h6);
    tick();
    chk("wb_rd_x6", bus.wb_instr.rd, 6'h06);
    bus.wb_ready     = 1'b0;
    bus.commit_instr = mk(ADD, 6'h28, 6'h01, 6'h02, 64'h8);
    #1;
    chk("ack_stall", bus.commit_ack, 0);
    tick();
    chk("wb_valid_stall", bus.wb_valid, 1);
    chk("wb_rd_stall", bus.wb_instr.rd, 6'h06);
    chk("gpr_stall", restore_gpr, 32'h60);
    tick();
    chk("wb_rd_stall2", bus.wb_instr.rd, 6'h06);
    bus.wb_ready = 1'b1;
    #1;
    chk("ack_resume", bus.commit_ack, 1);
    tick();
    chk("wb_rd_x8", bus.wb_instr.rd, 6'h08);
    chk("gpr_x8", restore_gpr, 32'h160);
    bus.commit_valid = 1'b0;
    tick();
    chk("wb_valid_drain", bus.wb_valid, 0);

    // flush coinciding with FPR accept
    bus.commit_valid = 1'b1;
    bus.commit_instr = mk(FADD, 6'h23, 6'h21, 6'h22, 64'h0);
    flush            = 1'b1;
    #1;
    chk("ack_flush", bus.commit_ack, 1);
    tick();
    flush            = 1'b0;
    bus.commit_valid = 1'b0;
    #1;
    chk("restore_valid", restore_valid, 1);
    chk("restore_fpr", restore_fpr, 32'h8);
    chk("restore_gpr", restore_gpr, 32'h160);
    chk("ack_restore", bus.commit_ack, 0);
    chk("wb_valid_flush", bus.wb_valid, 1);
    chk("wb_rd_f3", bus.wb_instr.rd, 6'h03);
    tick();
    chk("restore_end", restore_valid, 0);
    chk("ack_after_restore", bus.commit_ack, 1);
    chk("wb_valid_after", bus.wb_valid, 0);

    // flush held two cycles keeps RESTORE
    flush = 1'b1;
    tick();
    tick();
    chk("restore_hold", restore_valid, 1);
    flush = 1'b0;
    tick();
    chk("restore_release", restore_valid, 0);

    // fused op clears result name bit; f0 is renamed like any FPR
    bus.commit_valid = 1'b1;
    bus.commit_instr = mk(FMADD, 6'h24, 6'h21, 6'h22, 64'h3F);
    tick();
    chk("wb_rd_f4", bus.wb_instr.rd, 6'h04);
    chk("wb_res_f4", bus.wb_instr.result, 64'h1F);
    chk("wb_rs1_f4", bus.wb_instr.rs1, 6'h01);
    chk("fpr_f4", restore_fpr, 32'h18);
    bus.commit_instr = mk(FLD, 6'h20, 6'h01, 6'h00, 64'h0);
    tick();
    chk("fpr_f0", restore_fpr, 32'h19);
    chk("err_fpr", error, 0);

    // name mismatches
    bus.commit_instr = mk(ADD, 6'h07, 6'h01, 6'h02, 64'h7);
    tick();
    chk("err_x7a", error, CHK);
    chk("cnt_x7a", err_cnt, CHK ? 8'd1 : 8'd0);
    chk("gpr_x7a", restore_gpr, 32'h1E0);
    tick();
    chk("err_x7b", error, CHK);
    chk("cnt_x7b", err_cnt, CHK ? 8'd1 : 8'd0);
    chk("gpr_x7b", restore_gpr, 32'h160);
    bus.commit_instr = mk(ADD, 6'h20, 6'h00, 6'h00, 64'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("cnt_11", err_cnt, CHK ? 8'd11 : 8'd0);
    chk("gpr_x0_named", restore_gpr, 32'h160);
    for (int i = 0; i < 290; i++) tick();
    chk("cnt_sat", err_cnt, CHK ? 8'hFF : 8'h00);
    chk("err_sticky", error, CHK);
    bus.commit_valid = 1'b0;
    tick();

    // reset while output valid and in RESTORE
    bus.commit_valid = 1'b1;
    bus.commit_instr = mk(ADD, 6'h29, 6'h01, 6'h02, 64'h9);
    flush            = 1'b1;
    tick();
    chk("pre_rst_restore", restore_valid, 1);
    chk("pre_rst_wb_valid", bus.wb_valid, 1);
    rst = 1'b1;
    tick();
    chk("rst2_wb_valid", bus.wb_valid, 0);
    chk("rst2_restore_valid", restore_valid, 0);
    chk("rst2_gpr", restore_gpr, 0);
    chk("rst2_fpr", restore_fpr, 0);
    chk("rst2_error", error, 0);
    chk("rst2_cnt", err_cnt, 0);
    chk("rst2_ack", bus.commit_ack, 0);
    rst              = 1'b0;
    flush            = 1'b0;
    bus.commit_valid = 1'b0;
    #1;
    chk("ack_post_rst", bus.commit_ack, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
